// File: rtl/ascon_pkg.sv
// Shared constants, types and rotation lookups for the Ascon linear diffusion layer (pL).
package ascon_pkg;

  localparam int WORD_W = 64;
  localparam int NWORDS = 5;
  localparam int IDX_W  = $clog2(NWORDS);
  localparam int ROT_W  = 6;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [ROT_W-1:0]  rot_t;
  typedef logic [IDX_W-1:0]  idx_t;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} ll_state_t;

  localparam idx_t LAST_IDX = idx_t'(NWORDS - 1);

  localparam rot_t ROT0 [NWORDS] = '{6'd19, 6'd61, 6'd1, 6'd10, 6'd7};
  localparam rot_t ROT1 [NWORDS] = '{6'd28, 6'd39, 6'd6, 6'd17, 6'd41};

  // Out-of-range indices return a harmless nonzero rotation; idx never gets there.
  function automatic rot_t rot0_of(input idx_t i);
    rot_t r;
    if (int'(i) < NWORDS) r = ROT0[int'(i)];
    else                  r = 6'd1;
    return r;
  endfunction

  function automatic rot_t rot1_of(input idx_t i);
    rot_t r;
    if (int'(i) < NWORDS) r = ROT1[int'(i)];
    else                  r = 6'd1;
    return r;
  endfunction

endpackage

// File: rtl/ascon_word_diffuse.sv
// Combinational per-word diffusion: y = x ^ ror(x,a) ^ ror(x,b).
module ascon_word_diffuse
  import ascon_pkg::*;
(
  input  word_t      x,
  input  logic [5:0] a,
  input  logic [5:0] b,
  output word_t      y
);

  word_t ror_a;
  word_t ror_b;

  // Rotation amounts are always 1..63, so the complementary left shift never reaches 64.
  assign ror_a = (x >> a) | (x << (7'd64 - {1'b0, a}));
  assign ror_b = (x >> b) | (x << (7'd64 - {1'b0, b}));
  assign y     = x ^ ror_a ^ ror_b;

endmodule

// File: rtl/ascon_linear_layer.sv
// Ascon pL stage: captures the sbox output and diffuses one 64-bit word per cycle
// through a single shared rotator pair; result held in DONE until start drops.
module ascon_linear_layer
  import ascon_pkg::*;
#(
  parameter int CWIDTH = 320
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CWIDTH-1:0] state_in,
  output logic [CWIDTH-1:0] state_out,
  output logic              busy,
  output logic              done
);

  if (CWIDTH != WORD_W * NWORDS) begin : g_bad_width
    $error("ascon_linear_layer: CWIDTH must equal 64*NWORDS = 320");
  end

  ll_state_t         state;
  ll_state_t         state_next;
  idx_t              idx;
  logic [CWIDTH-1:0] in_reg;
  word_t             cur_word;
  word_t             diffused;

  assign cur_word = in_reg[WORD_W*idx +: WORD_W];

  ascon_word_diffuse u_diffuse (
    .x (cur_word),
    .a (rot0_of(idx)),
    .b (rot1_of(idx)),
    .y (diffused)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; DONE needs start low before re-arming
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) state_next = RUN;
        else       state_next = IDLE;
      end
      RUN: begin
        if (idx == LAST_IDX) state_next = DONE;
        else                 state_next = RUN;
      end
      DONE: begin
        if (start) state_next = DONE;
        else       state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output decode from the state register
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Datapath: capture, per-word write-back, index counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_reg    <= '0;
      idx       <= '0;
      state_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            in_reg <= state_in;
            idx    <= '0;
          end else begin
            idx    <= idx;
          end
        end
        RUN: begin
          state_out[WORD_W*idx +: WORD_W] <= diffused;
          if (idx == LAST_IDX) idx <= '0;
          else                 idx <= idx + idx_t'(1);
        end
        default: idx <= idx;
      endcase
    end
  end

endmodule
